// File: rtl/regs_pkg.sv
// Shared register-file constants, the writeback request record and a one-hot helper
// used by the writeback arbiter and its scoreboard.
package regs_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  localparam logic [AW-1:0] REG_X0 = 5'd0;
  localparam logic [AW-1:0] REG_SP = 5'd2;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // x0 is hard-wired zero, so it never maps to a scoreboard bit
  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] r);
    return (r == REG_X0) ? '0 : (NREG'(1) << r);
  endfunction

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Round-robin grant with a registered priority pointer; the search starts at the
// pointer and wraps, and the pointer moves to one past the granted requester.
module rr_arbiter_ptr #(
  parameter int NREQ = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     gnt_valid_o,
  output logic [$clog2(NREQ)-1:0]  gnt_idx_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_o[idx]  = 1'b1;
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
    // No grant may escape while reset is held, so nothing transfers that cycle
    if (rst) begin
      gnt_o       = '0;
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = (gnt_idx_o == IW'(NREQ - 1)) ? '0 : gnt_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters and tracks
// outstanding writes per register. Define REGS_WB_FORWARD_EN to add commit forwarding.
module regs_wb_arbiter
  import regs_pkg::wb_req_t, regs_pkg::NREG, regs_pkg::REG_X0, regs_pkg::reg_onehot;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 RegWrite,
  output logic [AW-1:0]        writeReg,
  output logic [XLEN-1:0]      writeData_R,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 busy1,
  output logic                 busy2,
`ifdef REGS_WB_FORWARD_EN
  output logic                 fwd1_valid,
  output logic                 fwd2_valid,
  output logic [XLEN-1:0]      fwd1_data,
  output logic [XLEN-1:0]      fwd2_data,
`endif
  output logic [NREG-1:0]      pending
);

  localparam int PW = $clog2(NREQ);

  // The request record takes its field widths from regs_pkg
  wb_req_t         req_s [NREQ];
  wb_req_t         sel_s;
  logic            xfer;
  logic [PW-1:0]   gnt_idx;

  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] set_vec, clr_vec;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_s[gi] = {req_valid[gi], req_rd[gi*AW +: AW], req_data[gi*XLEN +: XLEN]};
    end
  endgenerate

  rr_arbiter_ptr #(
    .NREQ (NREQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid),
    .gnt_o       (req_ready),
    .gnt_valid_o (xfer),
    .gnt_idx_o   (gnt_idx)
  );

  assign sel_s = req_s[gnt_idx];

  always_comb begin
    we_d    = xfer && sel_s.valid && (sel_s.rd != REG_X0);
    waddr_d = xfer ? sel_s.rd : waddr_q;
    wdata_d = xfer ? sel_s.data : wdata_q;
    clr_vec = xfer ? reg_onehot(sel_s.rd) : '0;
    set_vec = issue_valid ? reg_onehot(issue_rd) : '0;
    // A newly issued writer outranks a retiring one on the same register
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign RegWrite    = we_q;
  assign writeReg    = waddr_q;
  assign writeData_R = wdata_q;
  assign pending     = pending_q;

`ifdef REGS_WB_FORWARD_EN
  // A write committing this cycle satisfies the reader without a stall
  assign fwd1_valid = we_q && (waddr_q == rs1) && (rs1 != REG_X0);
  assign fwd2_valid = we_q && (waddr_q == rs2) && (rs2 != REG_X0);
  assign fwd1_data  = wdata_q;
  assign fwd2_data  = wdata_q;
  assign busy1      = pending_q[rs1] && (rs1 != REG_X0) && !fwd1_valid;
  assign busy2      = pending_q[rs2] && (rs2 != REG_X0) && !fwd2_valid;
`else
  assign busy1 = pending_q[rs1] && (rs1 != REG_X0);
  assign busy2 = pending_q[rs2] && (rs2 != REG_X0);
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed and randomized checks of regs_wb_arbiter against a behavioural model.
module tb_regs_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 RegWrite;
  logic [AW-1:0]        writeReg;
  logic [XLEN-1:0]      writeData_R;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        rs1, rs2;
  logic                 busy1, busy2;
  logic [31:0]          pending;
`ifdef REGS_WB_FORWARD_EN
  logic                 fwd1_valid, fwd2_valid;
  logic [XLEN-1:0]      fwd1_data, fwd2_data;
`endif

  always #5 clk = ~clk;

  regs_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .RegWrite    (RegWrite),
    .writeReg    (writeReg),
    .writeData_R (writeData_R),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy1       (busy1),
    .busy2       (busy2),
`ifdef REGS_WB_FORWARD_EN
    .fwd1_valid  (fwd1_valid),
    .fwd2_valid  (fwd2_valid),
    .fwd1_data   (fwd1_data),
    .fwd2_data   (fwd2_data),
`endif
    .pending     (pending)
  );

  // Requester-side state
  bit             b_v    [NREQ];
  bit [AW-1:0]    b_rd   [NREQ];
  bit [XLEN-1:0]  b_data [NREQ];

  // Reference model state
  int        m_ptr;
  bit        m_we;
  bit [4:0]  m_reg;
  bit [31:0] m_data;
  bit [31:0] m_pend;

  int checks = 0;
  int errors = 0;
  logic [NREQ-1:0] obs_ready;
  logic            obs_busy1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = b_v[i];
      req_rd[i*AW +: AW]        = b_rd[i];
      req_data[i*XLEN +: XLEN]  = b_data[i];
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic cycle();
    int g;
    int idx;
    logic [NREQ-1:0] er;
    bit eb1, eb2;
    drive();
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && b_v[idx]) g = idx;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    obs_ready = req_ready;
    obs_busy1 = busy1;
    chk("req_ready", req_ready, er);
    eb1 = (rs1 != 0) && m_pend[rs1];
    eb2 = (rs2 != 0) && m_pend[rs2];
`ifdef REGS_WB_FORWARD_EN
    begin
      bit f1, f2;
      f1 = m_we && (m_reg == rs1) && (rs1 != 0);
      f2 = m_we && (m_reg == rs2) && (rs2 != 0);
      chk("fwd1_valid", fwd1_valid, f1);
      chk("fwd2_valid", fwd2_valid, f2);
      if (f1) chk("fwd1_data", fwd1_data, m_data);
      if (f2) chk("fwd2_data", fwd2_data, m_data);
      eb1 = eb1 && !f1;
      eb2 = eb2 && !f2;
    end
`endif
    chk("busy1", busy1, eb1);
    chk("busy2", busy2, eb2);
    if (rst) begin
      m_ptr = 0; m_we = 0; m_reg = 0; m_data = 0; m_pend = 0;
    end else begin
      m_we = 0;
      if (g >= 0) begin
        m_we   = (b_rd[g] != 0);
        m_reg  = b_rd[g];
        m_data = b_data[g];
        m_ptr  = (g + 1) % NREQ;
        if (b_rd[g] != 0) m_pend[b_rd[g]] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("RegWrite", RegWrite, m_we);
    chk("writeReg", writeReg, m_reg);
    chk("writeData_R", writeData_R, m_data);
    chk("pending", pending, m_pend);
    if (g >= 0) b_v[g] = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((b_v[0] || b_v[1] || b_v[2]) && n < 10) begin
      cycle();
      n++;
    end
    chk("drain_done", {b_v[0], b_v[1], b_v[2]}, 3'b000);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    req_valid = '0; req_rd = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) begin b_v[i] = 0; b_rd[i] = 0; b_data[i] = 0; end
    m_ptr = 0; m_we = 0; m_reg = 0; m_data = 0; m_pend = 0;
    @(negedge clk);

    // Reset state, with a requester already knocking
    b_v[2] = 1; b_rd[2] = 5'd9; b_data[2] = 32'h1234;
    cycle();
    chk("rst_ready", obs_ready, 3'b000);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_pending", pending, 32'h0);
    b_v[2] = 0;
    rst = 1'b0;
    $display("reset: RegWrite=%0d pending=%08h", RegWrite, pending);

    // Single write
    b_v[1] = 1; b_rd[1] = 5'd10; b_data[1] = 32'hDEADBEEF;
    cycle();
    chk("single_ready", obs_ready, 3'b010);
    chk("single_we", RegWrite, 1'b1);
    chk("single_reg", writeReg, 5'd10);
    chk("single_data", writeData_R, 32'hDEADBEEF);
    $display("single: reg=%0d data=%08h", writeReg, writeData_R);

    // Fairness from reset with all requesters continuously valid
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!b_v[i]) begin b_v[i] = 1; b_rd[i] = 5'(i + 1); b_data[i] = 32'(k * 16 + i); end
      end
      cycle();
      chk("fair_order", obs_ready, 3'b001 << (k % 3));
      $display("fair: cycle %0d grant=%03b", k, obs_ready);
    end
    drain();

    // x0 write, together with an issue of x0
    b_v[0] = 1; b_rd[0] = 5'd0; b_data[0] = 32'hCAFE;
    issue_valid = 1; issue_rd = 5'd0;
    cycle();
    chk("x0_ready", obs_ready, 3'b001);
    chk("x0_we", RegWrite, 1'b0);
    chk("x0_pend0", pending[0], 1'b0);
    $display("x0: RegWrite=%0d pending=%08h", RegWrite, pending);

    // Scoreboard set, hazard, clear
    issue_valid = 1; issue_rd = 5'd5;
    cycle();
    rs1 = 5'd5;
    cycle();
    chk("sb_busy", obs_busy1, 1'b1);
    b_v[2] = 1; b_rd[2] = 5'd5; b_data[2] = 32'h55;
    cycle();
    chk("sb_pend5_clear", pending[5], 1'b0);
    cycle();
    chk("sb_busy_clear", obs_busy1, 1'b0);
    $display("scoreboard: busy1 after retire=%0d", obs_busy1);

    // Issue and retire the same register in one cycle, with competing requesters
    issue_valid = 1; issue_rd = 5'd7;
    cycle();
    b_v[0] = 1; b_rd[0] = 5'd7; b_data[0] = 32'h77;
    b_v[1] = 1; b_rd[1] = 5'd8; b_data[1] = 32'h88;
    issue_valid = 1; issue_rd = 5'd7;
    cycle();
    chk("simul_pend7", pending[7], 1'b1);
    chk("simul_onehot", $countones(obs_ready), 1);
    drain();
    $display("simultaneous: pending=%08h", pending);

    // Reset mid-stream
    rst = 1'b1; cycle(); rst = 1'b0;
    b_v[0] = 1; b_rd[0] = 5'd3; b_data[0] = 32'h33;
    issue_valid = 1; issue_rd = 5'd5;
    cycle();
    chk("pre_rst_pend", pending, 32'h20);
    b_v[1] = 1; b_rd[1] = 5'd11; b_data[1] = 32'hB1;
    b_v[2] = 1; b_rd[2] = 5'd12; b_data[2] = 32'hB2;
    rst = 1'b1;
    cycle();
    chk("midrst_ready", obs_ready, 3'b000);
    chk("midrst_we", RegWrite, 1'b0);
    chk("midrst_pend", pending, 32'h0);
    rst = 1'b0;
    b_v[0] = 1; b_rd[0] = 5'd13; b_data[0] = 32'hB0;
    cycle();
    chk("post_rst_first", obs_ready, 3'b001);
    drain();
    $display("midreset: first grant after release=%03b", obs_ready);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!b_v[i] && $urandom_range(0, 1) == 1) begin
          b_v[i] = 1; b_rd[i] = 5'($urandom_range(0, 31)); b_data[i] = $urandom;
        end
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      cycle();
    end
    rst = 1'b0;
    $display("random: 400 cycles, pending=%08h", pending);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite/writeReg/writeData_R) among NREQ writeback requesters, e.g. ALU, load unit and multi-cycle mul/div.
- Uses valid/ready handshakes and round-robin arbitration, and registers the write command so the register file sees it one cycle after the grant.
- Keeps a per-register pending scoreboard so the decode stage can stall on read-after-write hazards against outstanding multi-cycle results.

Parameters:
- NREQ, 3, number of writeback requesters (2..4).
- XLEN, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  requester i has a writeback pending.
- req_rd  in  NREQ*AW  destination register per requester; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*XLEN  write data per requester; same packing.
- req_ready  out  NREQ  one-hot grant; transfer happens when req_valid[i] && req_ready[i].
- RegWrite  out  1  write enable to the register file.
- writeReg  out  AW  write address to the register file.
- writeData_R  out  XLEN  write data to the register file.
- issue_valid  in  1  decode issues an instruction that will write rd later.
- issue_rd  in  AW  rd of the issued instruction.
- rs1, rs2  in  AW  decode source registers to check.
- busy1, busy2  out  1  the corresponding source has a pending write.
- pending  out  32  scoreboard vector, for debug and testbench.

Behaviour:
- Reset values: RegWrite=0, writeReg=0, writeData_R=0, pending=0, round-robin pointer=0. req_ready=0 in the cycle rst is high.
- Reset mid-operation discards any in-flight grant and clears the scoreboard.
- Arbitration (combinational ready):
  - Search begins at the requester index held in the pointer and wraps modulo NREQ.
  - The first requester with req_valid=1 gets ready=1; all others get 0.
  - No valid requester means no grant.
- Pointer update: on a transfer by requester g, the pointer becomes (g+1) mod NREQ. With no transfer it holds.
- Write stage (registered):
  - A transfer at cycle N produces RegWrite=1, writeReg=req_rd[g] and writeData_R=req_data[g] at cycle N+1.
  - Without a transfer, RegWrite=0 and writeReg/writeData_R hold their previous values.
  - Sustained throughput is 1 write per cycle.
- x0 handling:
  - A transfer with rd=0 is accepted (ready asserted) but drives RegWrite=0.
  - issue_rd=0 never sets a pending bit; pending[0] stays 0.
- Scoreboard:
  - Bit r is set on the cycle after issue_valid with issue_rd=r.
  - Bit r is cleared on the cycle after a transfer with rd=r.
  - Set and clear on the same register in the same cycle: set wins, because the newer producer is outstanding.
  - Setting an already pending register leaves it pending; there is no counter, so decode must not issue a second writer to a busy rd.
- Hazard outputs (combinational):
  - busy1 = pending[rs1]; busy2 = pending[rs2].
  - rs=0 always gives busy=0.
- Handshake rules:
  - Requesters must hold req_rd/req_data stable while valid and not ready.
  - req_valid may drop only after a transfer.
  - The block never grants more than one requester per cycle.

Optional Feature:
- Macro: REGS_WB_FORWARD_EN.
- With the macro defined:
  - Adds outputs fwd1_valid, fwd2_valid (1 bit each) and fwd1_data, fwd2_data (XLEN each).
  - When RegWrite=1 and writeReg equals rs1 (rs1≠0), fwd1_valid=1 and fwd1_data=writeData_R; rs2 side likewise.
  - busy1/busy2 are additionally forced to 0 when the matching fwd valid is asserted, so a same-cycle commit does not stall.
- Without the macro: these ports do not exist, and busy depends only on pending.

Decomposition:
- Shared package regs_pkg holds:
  - XLEN=32, AW=5, NREG=32.
  - REG_X0=5'd0, REG_SP=5'd2.
  - The writeback-request struct typedef {valid, rd, data}.
- One sub-module, rr_arbiter_ptr: a parameterised NREQ round-robin grant plus pointer register, reusable for a future memory-port arbiter.
- Scoreboard and write-stage registers stay in the top module.

Test Plan:
- Single write: requester 1 valid, rd=10, data=32'hDEADBEEF -> ready[1]=1 same cycle; next cycle RegWrite=1, writeReg=10, writeData_R=32'hDEADBEEF.
- Fairness: all three requesters valid continuously from reset -> grants in order 0,1,2,0,1,2; each requester is served once per 3 cycles.
- x0 write: requester 0, rd=0 -> ready[0]=1, next cycle RegWrite=0; pending[0] stays 0.
- Scoreboard: issue rd=5, then query rs1=5 -> busy1=1; transfer with rd=5 -> busy1=0 one cycle after the transfer.
- Simultaneous events: issue rd=7 in the same cycle as a transfer with rd=7 -> pending[7]=1 afterwards; same-cycle transfers from different requesters are never granted.
- Reset mid-stream: assert rst while two requesters are valid and pending=0x20 -> next cycle RegWrite=0, pending=0, pointer=0, and requester 0 is granted first after release.
